// File: rtl/can_pkg.sv
`default_nettype none
// +-------------------------------------------------------------+
// | can_pkg: shared CAN CRC/ACK checker types and CRC-15 fold    |
// | Revision: 1.0                                                |
// +-------------------------------------------------------------+
package can_pkg;

  localparam int CRC_LEN = 15;
  localparam logic [CRC_LEN-1:0] CRC_POLY_DEFAULT = 15'h4599;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    CRC_SEQ   = 3'd2,
    CRC_DELIM = 3'd3,
    ACK_SLOT  = 3'd4,
    ACK_DELIM = 3'd5,
    EOF_MARK  = 3'd6
  } can_state_e;

  // One serial CRC-15 step: shift left, XOR in the polynomial when the feedback is 1.
  function automatic logic [CRC_LEN-1:0] crc_fold(input logic [CRC_LEN-1:0] crc,
                                                  input logic               din,
                                                  input logic [CRC_LEN-1:0] poly);
    logic nxt;
    nxt      = din ^ crc[CRC_LEN-1];
    crc_fold = {crc[CRC_LEN-2:0], 1'b0} ^ ({CRC_LEN{nxt}} & poly);
  endfunction

endpackage
`default_nettype wire

// File: rtl/can_crc15.sv
`default_nettype none
// +-------------------------------------------------------------+
// | can_crc15: serial CAN CRC-15 register with clear-and-fold    |
// | Revision: 1.0                                                |
// +-------------------------------------------------------------+
module can_crc15
  import can_pkg::*;
#(
  parameter logic [CRC_LEN-1:0] POLY = CRC_POLY_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic               data_bit,
  output logic [CRC_LEN-1:0] crc
);

  // clear together with enable folds the bit into a freshly zeroed register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc <= '0;
    end else if (enable) begin
      crc <= crc_fold(clear ? '0 : crc, data_bit, POLY);
    end else if (clear) begin
      crc <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_crc_ack_check.sv
`default_nettype none
// +-------------------------------------------------------------+
// | can_crc_ack_check: CAN CRC/delimiter/ACK field checker       |
// | Revision: 1.0                                                |
// +-------------------------------------------------------------+
module can_crc_ack_check
  import can_pkg::*;
#(
  parameter logic [CRC_LEN-1:0] CRC_POLY = CRC_POLY_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic sp,
  input  logic rx,
  input  logic bit_valid,
  input  logic sof,
  input  logic data_end,
  output logic crc_error,
  output logic crc_delim_error,
  output logic ack_error,
  output logic ack_delim_error,
  output logic eof_flag
);

  can_state_e         state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic               crc_error_n, crc_delim_error_n, ack_error_n, ack_delim_error_n, eof_flag_n;
  logic               crc_clear, crc_en;
  logic               accept;
  logic [CRC_LEN-1:0] crc;
  logic [CRC_LEN-1:0] crc_post;

  assign accept   = sp & bit_valid;
  assign crc_post = crc_fold(crc, rx, CRC_POLY);

  can_crc15 #(.POLY(CRC_POLY)) u_crc (
    .clk      (clk),
    .reset    (reset),
    .clear    (crc_clear),
    .enable   (crc_en),
    .data_bit (rx),
    .crc      (crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      crc_error       <= 1'b0;
      crc_delim_error <= 1'b0;
      ack_error       <= 1'b0;
      ack_delim_error <= 1'b0;
      eof_flag        <= 1'b1;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      crc_error       <= crc_error_n;
      crc_delim_error <= crc_delim_error_n;
      ack_error       <= ack_error_n;
      ack_delim_error <= ack_delim_error_n;
      eof_flag        <= eof_flag_n;
    end
  end

  always_comb begin
    state_n           = state;
    cnt_n             = cnt;
    crc_error_n       = crc_error;
    crc_delim_error_n = crc_delim_error;
    ack_error_n       = ack_error;
    ack_delim_error_n = ack_delim_error;
    eof_flag_n        = eof_flag;
    crc_clear         = 1'b0;
    crc_en            = 1'b0;

    // The EOF marker is released on any sample point, stuff bit or not.
    if (sp && state == EOF_MARK) begin
      eof_flag_n = 1'b1;
      state_n    = IDLE;
    end

    if (accept) begin
      if (sof) begin
        crc_error_n       = 1'b0;
        crc_delim_error_n = 1'b0;
        ack_error_n       = 1'b0;
        ack_delim_error_n = 1'b0;
        crc_clear         = 1'b1;
        crc_en            = 1'b1;
        state_n           = DATA;
      end else begin
        case (state)
          DATA: begin
            crc_en = 1'b1;
            if (data_end) begin
              cnt_n   = 4'd0;
              state_n = CRC_SEQ;
            end
          end
          CRC_SEQ: begin
            crc_en = 1'b1;
            cnt_n  = cnt + 4'd1;
            if (cnt == 4'd14) begin
              if (crc_post != '0) crc_error_n = 1'b1;
              state_n = CRC_DELIM;
            end
          end
          CRC_DELIM: begin
            if (!rx) begin
              crc_delim_error_n = 1'b1;
              state_n           = IDLE;
            end else begin
              state_n = ACK_SLOT;
            end
          end
          ACK_SLOT: begin
            if (rx) ack_error_n = 1'b1;
            state_n = ACK_DELIM;
          end
          ACK_DELIM: begin
            if (!rx) begin
              ack_delim_error_n = 1'b1;
              state_n           = IDLE;
            end else begin
              eof_flag_n = 1'b0;
              state_n    = EOF_MARK;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
